// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: valid/ready handshake, 2-entry skid
// buffer, synchronous flush and bubble-safe control outputs.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [ADDR_W-1:0] in_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [ADDR_W-1:0] out_rd_o,
  output logic [1:0]        occupancy_o
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [ADDR_W-1:0] main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic              push, pop;

  // Handshake flags come from registered state only; no ready-to-ready path.
  assign in_ready_o  = (state_q != S_TWO);
  assign out_valid_o = (state_q != S_EMPTY);
  assign occupancy_o = state_q;

  assign push = in_valid_i & in_ready_o & start_i;
  assign pop  = out_valid_o & out_ready_i & start_i;

  assign out_data_o = main_data_q;
  assign out_rd_o   = main_rd_q;
  assign out_ctrl_o = out_valid_o ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_rd_d   = main_rd_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rd_d   = skid_rd_q;
    if (start_i) begin
      if (flush_i) begin
        state_d = S_EMPTY;
      end else begin
        unique case (state_q)
          S_EMPTY: begin
            if (push) begin
              state_d     = S_ONE;
              main_data_d = in_data_i;
              main_ctrl_d = in_ctrl_i;
              main_rd_d   = in_rd_i;
            end
          end
          S_ONE: begin
            if (push && pop) begin
              main_data_d = in_data_i;
              main_ctrl_d = in_ctrl_i;
              main_rd_d   = in_rd_i;
            end else if (push) begin
              state_d     = S_TWO;
              skid_data_d = in_data_i;
              skid_ctrl_d = in_ctrl_i;
              skid_rd_d   = in_rd_i;
            end else if (pop) begin
              state_d = S_EMPTY;
            end
          end
          S_TWO: begin
            if (pop) begin
              state_d     = S_ONE;
              main_data_d = skid_data_q;
              main_ctrl_d = skid_ctrl_q;
              main_rd_d   = skid_rd_q;
            end
          end
          default: state_d = S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_rd_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_rd_q   <= main_rd_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: scenario tasks plus a queue-based reference model
// that checks handshake flags, occupancy and FIFO ordering every cycle.
module tb_pipe_stage_reg;

  logic        clk, rst_i, start_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [63:0] in_data_i, out_data_o;
  logic [3:0]  in_ctrl_i, out_ctrl_o;
  logic [4:0]  in_rd_i, out_rd_o;
  logic [1:0]  occupancy_o;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  c;
    logic [4:0]  r;
  } ent_t;

  ent_t sb[$];
  int   checks, failures;
  bit   mon_en;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_ctrl_i(in_ctrl_i), .in_rd_i(in_rd_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o),
    .out_rd_o(out_rd_o), .occupancy_o(occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Reference model: sampled mid-cycle, commits what the coming edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      int  n;
      bit  do_pop, do_push;
      ent_t e;
      n = sb.size();
      checks++;
      if (occupancy_o !== 2'(n)) begin
        failures++;
        $display("FAIL mon_occupancy: got %0d expected %0d at %0t", occupancy_o, n, $time);
      end
      checks++;
      if (in_ready_o !== (n < 2) || out_valid_o !== (n > 0)) begin
        failures++;
        $display("FAIL mon_flags: in_ready=%b out_valid=%b expected %b %b at %0t",
                 in_ready_o, out_valid_o, n < 2, n > 0, $time);
      end
      if (n == 0) begin
        checks++;
        if (out_ctrl_o !== 4'h0) begin
          failures++;
          $display("FAIL mon_bubble_ctrl: got %h expected 0 at %0t", out_ctrl_o, $time);
        end
      end
      if (start_i) begin
        do_pop  = (n > 0) && out_ready_i;
        do_push = in_valid_i && (n < 2) && !flush_i;
        if (do_pop) begin
          e = sb.pop_front();
          checks++;
          if (out_data_o !== e.d || out_ctrl_o !== e.c || out_rd_o !== e.r) begin
            failures++;
            $display("FAIL mon_pop_order: got d=%h c=%h r=%h expected d=%h c=%h r=%h at %0t",
                     out_data_o, out_ctrl_o, out_rd_o, e.d, e.c, e.r, $time);
          end
        end
        if (flush_i) sb.delete();
        if (do_push) begin
          e.d = in_data_i; e.c = in_ctrl_i; e.r = in_rd_i;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step(input bit vi, input logic [63:0] d, input logic [3:0] c,
                      input logic [4:0] r, input bit ordy, input bit st = 1'b1,
                      input bit fl = 1'b0);
    in_valid_i  = vi;
    in_data_i   = d;
    in_ctrl_i   = c;
    in_rd_i     = r;
    out_ready_i = ordy;
    start_i     = st;
    flush_i     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    out_ready_i = 1'b0; in_data_i = '0; in_ctrl_i = '0; in_rd_i = '0;
    #12;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || occupancy_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b ready=%b occ=%0d expected 0 1 0",
               out_valid_o, in_ready_o, occupancy_o);
    end
    checks++;
    if (out_data_o !== 64'h0 || out_ctrl_o !== 4'h0 || out_rd_o !== 5'h0) begin
      failures++;
      $display("FAIL reset_payload: d=%h c=%h r=%h expected all 0", out_data_o, out_ctrl_o, out_rd_o);
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_stream();
    logic [63:0] vals [3] = '{64'h11, 64'h22, 64'h33};
    foreach (vals[i]) begin
      step(1'b1, vals[i], 4'h3, 5'(i + 1), 1'b1);
      checks++;
      if (out_data_o !== vals[i] || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: d=%h occ=%0d ready=%b expected %h 1 1",
                 i, out_data_o, occupancy_o, in_ready_o, vals[i]);
      end
    end
    step(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_skid();
    step(1'b1, 64'hA0, 4'h1, 5'd10, 1'b0);
    step(1'b1, 64'hA1, 4'h2, 5'd11, 1'b0);
    checks++;
    if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL skid_full: occ=%0d ready=%b expected 2 0", occupancy_o, in_ready_o);
    end
    step(1'b1, 64'hA2, 4'h4, 5'd12, 1'b0);
    checks++;
    if (occupancy_o !== 2'd2 || out_data_o !== 64'hA0) begin
      failures++;
      $display("FAIL skid_reject: occ=%0d d=%h expected 2 a0", occupancy_o, out_data_o);
    end
    step(1'b1, 64'hA2, 4'h4, 5'd12, 1'b1);
    checks++;
    if (out_data_o !== 64'hA1 || occupancy_o !== 2'd1) begin
      failures++;
      $display("FAIL skid_drain1: d=%h occ=%0d expected a1 1", out_data_o, occupancy_o);
    end
    step(1'b1, 64'hA2, 4'h4, 5'd12, 1'b1);
    checks++;
    if (out_data_o !== 64'hA2 || out_rd_o !== 5'd12) begin
      failures++;
      $display("FAIL skid_drain2: d=%h rd=%0d expected a2 12", out_data_o, out_rd_o);
    end
    step(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, 64'hB0, 4'h5, 5'd1, 1'b0);
    step(1'b1, 64'hB1, 4'h6, 5'd2, 1'b0);
    step(1'b1, 64'h55, 4'hF, 5'd3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_ctrl_o !== 4'h0) begin
      failures++;
      $display("FAIL flush_empty: occ=%0d valid=%b ctrl=%h expected 0 0 0",
               occupancy_o, out_valid_o, out_ctrl_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      checks++;
      if (out_data_o === 64'h55 || out_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL flush_dropped: d=%h valid=%b expected not 55, valid 0", out_data_o, out_valid_o);
      end
    end
  endtask

  task automatic test_freeze();
    step(1'b1, 64'h77, 4'b1001, 5'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'h99, 4'h2, 5'd9, 1'b1, 1'b0);
      checks++;
      if (occupancy_o !== 2'd1 || out_data_o !== 64'h77 || out_ctrl_o !== 4'b1001) begin
        failures++;
        $display("FAIL freeze_hold_%0d: occ=%0d d=%h c=%b expected 1 77 1001",
                 i, occupancy_o, out_data_o, out_ctrl_o);
      end
    end
    step(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (occupancy_o !== 2'd0 || out_ctrl_o !== 4'h0) begin
      failures++;
      $display("FAIL freeze_release: occ=%0d ctrl=%h expected 0 0", occupancy_o, out_ctrl_o);
    end
  endtask

  task automatic test_bubble();
    step(1'b1, 64'hBEEF, 4'hF, 5'h1A, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (out_valid_o !== 1'b0 || out_ctrl_o !== 4'h0 || out_data_o !== 64'hBEEF || out_rd_o !== 5'h1A) begin
      failures++;
      $display("FAIL bubble_ctrl: valid=%b c=%h d=%h r=%h expected 0 0 beef 1a",
               out_valid_o, out_ctrl_o, out_data_o, out_rd_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 4'($urandom), 5'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (sb.size() != 0 || occupancy_o !== 2'd0) begin
      failures++;
      $display("FAIL b2b_drain: model=%0d occ=%0d expected 0 0", sb.size(), occupancy_o);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 64'hC0, 4'h7, 5'd20, 1'b0);
    step(1'b1, 64'hC1, 4'h8, 5'd21, 1'b0);
    checks++;
    if (occupancy_o !== 2'd2) begin
      failures++;
      $display("FAIL areset_fill: occ=%0d expected 2", occupancy_o);
    end
    in_valid_i = 1'b0;
    #2;
    mon_en = 1'b0;
    rst_i  = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL areset_flags: valid=%b occ=%0d ready=%b expected 0 0 1",
               out_valid_o, occupancy_o, in_ready_o);
    end
    checks++;
    if (out_data_o !== 64'h0 || out_ctrl_o !== 4'h0 || out_rd_o !== 5'h0) begin
      failures++;
      $display("FAIL areset_payload: d=%h c=%h r=%h expected all 0", out_data_o, out_ctrl_o, out_rd_o);
    end
    sb.delete();
    @(posedge clk); #3;
    rst_i = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(1'b1, 64'hD0, 4'h1, 5'd3, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0; mon_en = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_freeze();
    test_bubble();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
